down_counter: RTL
=================

# down_counter

Loadable, parameterised down-counter (countdown timer) built on the team's edge-triggered flip-flop style. It complements the existing up-counter: it counts from a loaded value toward zero and signals terminal count. It supports one-shot and auto-reload modes and exposes both true (`Q`) and complemented (`Qbar`) outputs. It sits beside the counter in the counter project and generates periodic ticks or timeouts for other blocks.

## Interface
- `WIDTH`, default 8: counter and load-value width in bits.
- `C` in 1: clock; all state changes on the rising edge.
- `R` in 1: reset; asynchronous, active-low (`R`=0 resets immediately, independent of `C`).
- `ld` in 1: load strobe; captures `D` into the reload register and `Q`.
- `D` in `WIDTH`: load value.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `en` in 1: count enable; one decrement per enabled cycle in RUN.
- `mode` in 1: 0 = one-shot, 1 = auto-reload.
- `Q` out `WIDTH`: current count.
- `Qbar` out `WIDTH`: bitwise `~Q`, always.
- `tc` out 1: terminal-count pulse, exactly one cycle wide.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE (one-shot expired).

## Operation
- Registers:
  - `Q`
  - reload register `RV`
  - state: IDLE, RUN or DONE
  - `tc`
- `busy` and `done` are decoded from the state register and are glitch-free.
- Reset (`R`=0):
  - `Q`=0, `Qbar`=all ones, `RV`=0.
  - State IDLE, `tc`=0, `busy`=0, `done`=0.
  - Reset held low overrides all inputs. Reset mid-RUN aborts the count immediately.
- Priority when inputs coincide: `ld` > `stop` > `start` > count.
- `ld`=1 (any state): `RV`<=`D`, `Q`<=`D`, state<=IDLE, `tc`<=0.
- `stop`=1 in RUN: state<=IDLE and `Q` holds. `stop` in IDLE or DONE has no effect.
- `start`=1:
  - In IDLE with `Q`!=0: state<=RUN.
  - In IDLE with `Q`==0: ignored.
  - In DONE with `RV`!=0: `Q`<=`RV`, state<=RUN (restart).
  - In DONE with `RV`==0: ignored.
  - In RUN: no effect.
- RUN, `en`=0: `Q` holds, `tc`=0.
- RUN, `en`=1, `Q`>1: `Q`<=`Q`-1.
- RUN, `en`=1, `Q`==1:
  - `tc`<=1.
  - One-shot (`mode`=0): `Q`<=0, state<=DONE.
  - Auto-reload (`mode`=1): `Q`<=`RV`, stays in RUN. The period is exactly `RV` enabled cycles, and `Q` never shows 0 in this mode.
- `mode` is sampled on each terminal-count event. Changing it mid-count takes effect at the next terminal count.
- `Q` never underflows: no decrement occurs from 0.
- `tc` is 0 in every cycle not described above.

## Timing
- All outputs are registered. `Qbar` is combinational from `Q` only.
- `start` sampled at edge k: `busy`=1 after edge k, and the first decrement occurs at edge k+1 if `en`=1.
- One-shot, loaded value N, `en` held high, `start` at edge k:
  - `tc`=1 and `Q`=0 for exactly the cycle after edge k+N.
  - `done`=1 from edge k+N onward.
- `ld` latency is 1 edge: `Q`=`D` after the edge at which `ld` is sampled high.
- `tc` falls at the next edge, even if `en` drops.

## Test plan
- Reset: drive `R`=0 asynchronously mid-RUN with `Q`=0x23 → `Q`=0x00, `Qbar`=0xFF, `busy`=0, `done`=0, `tc`=0 without a clock edge. Release → IDLE.
- One-shot: `ld` with `D`=5, `mode`=0, `start`, `en`=1 → `Q` goes 5,4,3,2,1,0. `tc` is high exactly once, in the cycle `Q`=0, and `done`=1 afterward.
- Auto-reload: `D`=3, `mode`=1, `en`=1 for 12 cycles → `Q` sequence 3,2,1,3,2,1,…. `tc` is high every 3rd cycle, with `Q`=3 in those cycles. `busy` stays 1.
- Enable gating and stop/resume: `D`=4 with `en` toggling 1,0,1,0 → `Q` decrements only on `en`=1 cycles. `stop` at `Q`=2 → IDLE and `Q` holds at 2. `start` → resumes at 2,1,0.
- Priority: assert `ld`(`D`=7), `stop` and `start` in the same cycle while in RUN → `Q`=7, state IDLE, `busy`=0. Assert `start` with `Q`=0 in IDLE → stays IDLE.
- Restart from DONE and `Qbar`: after a one-shot with `RV`=2, assert `start` → `Q`=2, RUN, `done`=0. Check `Qbar`==~`Q` on every cycle throughout.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down-counter / countdown timer with one-shot and auto-reload modes.
// Counts a loaded value toward zero and pulses tc for one cycle at terminal count.
module down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // Each non-idle state owns one bit, so busy/done come straight off a flop.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rv_q, rv_d;
    logic [1:0]       state_q, state_d;
    logic             tc_q, tc_d;

    always_comb begin
        q_d     = q_q;
        rv_d    = rv_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (ld) begin
            rv_d    = D;
            q_d     = D;
            state_d = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start && state_q == IDLE && q_q != '0) begin
            state_d = RUN;
        end else if (start && state_q == DONE && rv_q != '0) begin
            q_d     = rv_q;
            state_d = RUN;
        end else if (state_q == RUN && en) begin
            if (q_q > ONE) begin
                q_d = q_q - ONE;
            end else if (q_q == ONE) begin
                tc_d = 1'b1;
                if (mode) begin
                    q_d = rv_q;
                end else begin
                    q_d     = '0;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            q_q     <= '0;
            rv_q    <= '0;
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            q_q     <= q_d;
            rv_q    <= rv_d;
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign tc   = tc_q;
    assign busy = state_q[0];
    assign done = state_q[1];

endmodule
